phase_cmd_receiver: RTL and testbench
=====================================

PHASE_CMD_RECEIVER -- requirements
Module: phase_cmd_receiver

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 256, meaning system clock frequency used to derive phase resolution.
REQ-002 SHALL have parameter OUT_FREQ, default 1, meaning transducer drive frequency; PHASE_W = $clog2(CLK_FREQ/OUT_FREQ).
REQ-003 SHALL have parameter NUM_CHANNELS, default 10, meaning number of phase channels.
REQ-004 SHALL have parameter TX_FIFO_LOAD_W, default 13, meaning width of txfifo_load.
REQ-005 SHALL have parameter RX_FIFO_LOAD_W, default 13, meaning width of rxfifo_load.
REQ-006 SHALL have parameter TIMEOUT_CYCLES, default 1024, meaning maximum idle cycles allowed mid-command.
REQ-007 SHALL use one clock and a synchronous, active-high reset; ports: clk input 1 system clock; rst input 1 synchronous active-high reset.
REQ-008 SHALL have ports: rxfifo_data input 8 host byte; rxfifo_valid input 1 byte present; rxfifo_load input RX_FIFO_LOAD_W (unused); rxfifo_empty input 1 RX FIFO empty; rxfifo_rd output 1 read strobe.
REQ-009 SHALL have ports: txfifo_load input TX_FIFO_LOAD_W (unused); txfifo_full input 1 TX FIFO full; txfifo_wr output 1 write strobe; txfifo_data output 8 byte to host.
REQ-010 SHALL have ports: phases output PHASE_W x NUM_CHANNELS active phases; read_error output 1 error pulse; commit output 1 commit pulse.

Function
REQ-011 SHALL derive PHASE_BYTES = ceil(PHASE_W/8) and ADDR_BYTES = max(1, ceil($clog2(NUM_CHANNELS)/8)); multi-byte fields are big-endian; unused upper phase bits are ignored.
REQ-012 SHALL assert rxfifo_rd when !rxfifo_empty and state is not TX; a byte is consumed only in a cycle with rxfifo_valid=1.
REQ-013 SHALL implement states IDLE, ADDR, DATA, BURST, TX; IDLE decodes opcode byte.
REQ-014 Opcode 0x01 SET: IDLE->ADDR (ADDR_BYTES)->DATA (PHASE_BYTES)->write shadow[addr]->IDLE.
REQ-015 Opcode 0x02 BURST: IDLE->BURST, receives NUM_CHANNELS x PHASE_BYTES bytes, writes shadow[0..N-1] in order, ->IDLE after last.
REQ-016 Opcode 0x03 COMMIT: copies all shadow to phases in the cycle after the opcode byte; commit pulses 1 cycle same cycle phases update.
REQ-017 Opcode 0x04 READ: IDLE->ADDR->TX; TX writes PHASE_BYTES bytes of phases[addr] (active, MSB first) with txfifo_wr only when !txfifo_full, then ->IDLE.
REQ-018 Unknown opcode: read_error pulses 1 cycle, byte discarded, stay IDLE.
REQ-019 addr >= NUM_CHANNELS: data bytes (SET) still consumed, shadow unchanged, read_error pulses at last byte; READ with bad addr pulses read_error, sends nothing, ->IDLE.
REQ-020 In ADDR/DATA/BURST, TIMEOUT_CYCLES consecutive cycles without valid byte SHALL abort to IDLE with read_error pulse; partial BURST writes already made remain in shadow.
REQ-021 phases SHALL change only on COMMIT or reset; SET/BURST never alter phases directly.
REQ-022 read_error and commit SHALL never be asserted for more than one cycle per event.

Reset
REQ-023 rst SHALL clear phases and shadow to 0, state to IDLE, timeout counter to 0, rxfifo_rd/txfifo_wr/read_error/commit to 0, txfifo_data to 0.
REQ-024 rst mid-command SHALL discard the partial command; first byte after reset is decoded as opcode.

Structure
REQ-025 Package phase_rx_pkg SHALL hold opcode enum (OP_SET, OP_BURST, OP_COMMIT, OP_READ) and state enum.
REQ-026 Timeout counter SHALL be sub-module cmd_timer (inputs clk, rst, clear, enable; output expired).

Verification (CLK_FREQ=256 unless noted: PHASE_W=8, 1-byte fields)
REQ-027 Bytes 01 03 7F, then 03 -> phases[3]=0x7F one cycle after 03 with commit pulse; other phases 0.
REQ-028 Bytes 02 then 00..09 (10 bytes), then 03 -> phases[i]=i for i=0..9.
REQ-029 Bytes 01 0C 55 -> read_error pulse once, shadow unchanged; byte 77 in IDLE -> read_error pulse.
REQ-030 After commit phases[3]=0x7F, bytes 04 03 with txfifo_full held 5 cycles -> no txfifo_wr until full drops, then one write of 0x7F.
REQ-031 CLK_FREQ=4096 (PHASE_W=12): bytes 01 02 0A BC, 03 -> phases[2]=0xABC.
REQ-032 Bytes 01 05 then no data for TIMEOUT_CYCLES -> read_error pulse, IDLE; next 03 commits with phases[5] unchanged.

Source files
------------

// File: rtl/phase_rx_pkg.sv
// Shared opcode/state encodings and field-sizing helper for the phase command receiver.
package phase_rx_pkg;

   typedef enum logic [7:0] {
      OP_SET    = 8'h01,
      OP_BURST  = 8'h02,
      OP_COMMIT = 8'h03,
      OP_READ   = 8'h04
   } opcode_e;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_BURST,
      ST_TX
   } state_e;

   function automatic int bytes_for(input int bits);
      return (bits + 7) / 8;
   endfunction

endpackage

// File: rtl/phase_cmd_receiver_timer.sv
// Mid-command idle watchdog: expired is high on the TIMEOUT_CYCLES-th consecutive enabled cycle.
// Any cycle with clear set (or enable low at the parent) restarts the count from zero.
module cmd_timer #(
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int            CW   = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && (cnt_q != LAST)) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/phase_cmd_receiver.sv
// Host byte-stream decoder: SET/BURST fill a shadow table, COMMIT copies it to phases, READ echoes one phase.
// Outputs are registered (one cycle after the consuming byte); TX bytes are only written while txfifo_full is low.
module phase_cmd_receiver
   import phase_rx_pkg::*;
#(
   parameter int  CLK_FREQ       = 256,
   parameter int  OUT_FREQ       = 1,
   parameter int  NUM_CHANNELS   = 10,
   parameter int  TX_FIFO_LOAD_W = 13,
   parameter int  RX_FIFO_LOAD_W = 13,
   parameter int  TIMEOUT_CYCLES = 1024,
   localparam int PHASE_W        = $clog2(CLK_FREQ / OUT_FREQ)
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [7:0]                           rxfifo_data,
   input  logic                                 rxfifo_valid,
   input  logic [RX_FIFO_LOAD_W-1:0]            rxfifo_load,
   input  logic                                 rxfifo_empty,
   output logic                                 rxfifo_rd,
   input  logic [TX_FIFO_LOAD_W-1:0]            txfifo_load,
   input  logic                                 txfifo_full,
   output logic                                 txfifo_wr,
   output logic [7:0]                           txfifo_data,
   output logic [NUM_CHANNELS-1:0][PHASE_W-1:0] phases,
   output logic                                 read_error,
   output logic                                 commit
);
   localparam int PHASE_BYTES = bytes_for(PHASE_W);
   localparam int ADDR_BYTES  = (bytes_for($clog2(NUM_CHANNELS)) > 1) ? bytes_for($clog2(NUM_CHANNELS)) : 1;
   localparam int PBW         = PHASE_BYTES * 8;
   localparam int AW          = ADDR_BYTES * 8;
   localparam int IDX_W       = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

   localparam logic [7:0]       PB_LAST = 8'(PHASE_BYTES - 1);
   localparam logic [7:0]       AB_LAST = 8'(ADDR_BYTES - 1);
   localparam logic [AW:0]      NCH     = (AW + 1)'(NUM_CHANNELS);
   localparam logic [IDX_W-1:0] CH_LAST = IDX_W'(NUM_CHANNELS - 1);

   state_e                               state_q, state_d;
   opcode_e                              op_q, op_d;
   logic [AW-1:0]                        addr_q, addr_d, addr_sh;
   logic [PBW-1:0]                       data_q, data_d, data_sh;
   logic [7:0]                           bcnt_q, bcnt_d;
   logic [IDX_W-1:0]                     ch_q, ch_d;
   logic [NUM_CHANNELS-1:0][PHASE_W-1:0] shadow_q, shadow_d;
   logic [NUM_CHANNELS-1:0][PHASE_W-1:0] phases_q, phases_d;
   logic                                 err_q, err_d;
   logic                                 commit_q, commit_d;
   logic                                 txwr_q, txwr_d;
   logic [7:0]                           txdat_q, txdat_d;

   logic byte_vld, busy, expired, sh_addr_ok, cur_addr_ok;
   logic unused_load;

   assign unused_load = ^{rxfifo_load, txfifo_load};

   assign byte_vld    = rxfifo_valid && (state_q != ST_TX);
   assign busy        = (state_q == ST_ADDR) || (state_q == ST_DATA) || (state_q == ST_BURST);
   assign rxfifo_rd   = !rst && !rxfifo_empty && (state_q != ST_TX);
   // Multi-byte fields arrive MSB first, so each byte shifts in at the bottom.
   assign addr_sh     = (addr_q << 8) | AW'(rxfifo_data);
   assign data_sh     = (data_q << 8) | PBW'(rxfifo_data);
   assign sh_addr_ok  = ({1'b0, addr_sh} < NCH);
   assign cur_addr_ok = ({1'b0, addr_q} < NCH);

   cmd_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (!(busy && !byte_vld)),
      .enable (busy && !byte_vld),
      .expired(expired)
   );

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      addr_d   = addr_q;
      data_d   = data_q;
      bcnt_d   = bcnt_q;
      ch_d     = ch_q;
      shadow_d = shadow_q;
      phases_d = phases_q;
      err_d    = 1'b0;
      commit_d = 1'b0;
      txwr_d   = 1'b0;
      txdat_d  = txdat_q;

      case (state_q)
         ST_IDLE: if (byte_vld) begin
            bcnt_d = '0;
            addr_d = '0;
            data_d = '0;
            ch_d   = '0;
            case (rxfifo_data)
               OP_SET:    begin state_d = ST_ADDR; op_d = OP_SET; end
               OP_READ:   begin state_d = ST_ADDR; op_d = OP_READ; end
               OP_BURST:  state_d = ST_BURST;
               OP_COMMIT: begin phases_d = shadow_q; commit_d = 1'b1; end
               default:   err_d = 1'b1;
            endcase
         end
         ST_ADDR: if (byte_vld) begin
            addr_d = addr_sh;
            if (bcnt_q == AB_LAST) begin
               bcnt_d = '0;
               if (op_q == OP_SET) begin
                  state_d = ST_DATA;
                  data_d  = '0;
               end else if (sh_addr_ok) begin
                  state_d = ST_TX;
                  data_d  = PBW'(phases_q[IDX_W'(addr_sh)]);
               end else begin
                  state_d = ST_IDLE;
                  err_d   = 1'b1;
               end
            end else begin
               bcnt_d = bcnt_q + 8'd1;
            end
         end
         ST_DATA: if (byte_vld) begin
            data_d = data_sh;
            if (bcnt_q == PB_LAST) begin
               state_d = ST_IDLE;
               if (cur_addr_ok) shadow_d[IDX_W'(addr_q)] = data_sh[PHASE_W-1:0];
               else             err_d = 1'b1;
            end else begin
               bcnt_d = bcnt_q + 8'd1;
            end
         end
         ST_BURST: if (byte_vld) begin
            data_d = data_sh;
            if (bcnt_q == PB_LAST) begin
               bcnt_d         = '0;
               shadow_d[ch_q] = data_sh[PHASE_W-1:0];
               if (ch_q == CH_LAST) state_d = ST_IDLE;
               else                 ch_d    = ch_q + IDX_W'(1);
            end else begin
               bcnt_d = bcnt_q + 8'd1;
            end
         end
         ST_TX: if (!txfifo_full) begin
            txwr_d  = 1'b1;
            txdat_d = data_q[PBW-1 -: 8];
            data_d  = data_q << 8;
            if (bcnt_q == PB_LAST) state_d = ST_IDLE;
            else                   bcnt_d  = bcnt_q + 8'd1;
         end
         default: state_d = ST_IDLE;
      endcase

      // A stalled command is abandoned; completed BURST entries stay in shadow.
      if (expired) begin
         state_d = ST_IDLE;
         err_d   = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_SET;
         addr_q   <= '0;
         data_q   <= '0;
         bcnt_q   <= '0;
         ch_q     <= '0;
         shadow_q <= '0;
         phases_q <= '0;
         err_q    <= 1'b0;
         commit_q <= 1'b0;
         txwr_q   <= 1'b0;
         txdat_q  <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         addr_q   <= addr_d;
         data_q   <= data_d;
         bcnt_q   <= bcnt_d;
         ch_q     <= ch_d;
         shadow_q <= shadow_d;
         phases_q <= phases_d;
         err_q    <= err_d;
         commit_q <= commit_d;
         txwr_q   <= txwr_d;
         txdat_q  <= txdat_d;
      end
   end

   assign phases      = phases_q;
   assign read_error  = err_q;
   assign commit      = commit_q;
   assign txfifo_wr   = txwr_q;
   assign txfifo_data = txdat_q;

endmodule

// File: tb/tb_phase_cmd_receiver.sv
// Directed bench: an 8-bit-phase instance and a 12-bit-phase instance share the host byte stream.
module tb_phase_cmd_receiver;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a, rst_b;
   logic [7:0]  rx_data;
   logic        rx_valid, rx_empty, tx_full;
   logic [12:0] rx_load, tx_load;

   logic             rd_a, wr_a, err_a, com_a;
   logic [7:0]       txd_a;
   logic [9:0][7:0]  ph_a, exp_a;
   logic             rd_b, wr_b, err_b, com_b;
   logic [7:0]       txd_b;
   logic [9:0][11:0] ph_b, exp_b;

   int total = 0;
   int bad   = 0;
   int n;
   int nwr;
   logic [15:0] wdat;

   phase_cmd_receiver dut_a (
      .clk(clk), .rst(rst_a),
      .rxfifo_data(rx_data), .rxfifo_valid(rx_valid), .rxfifo_load(rx_load),
      .rxfifo_empty(rx_empty), .rxfifo_rd(rd_a),
      .txfifo_load(tx_load), .txfifo_full(tx_full), .txfifo_wr(wr_a), .txfifo_data(txd_a),
      .phases(ph_a), .read_error(err_a), .commit(com_a)
   );

   phase_cmd_receiver #(.CLK_FREQ(4096)) dut_b (
      .clk(clk), .rst(rst_b),
      .rxfifo_data(rx_data), .rxfifo_valid(rx_valid), .rxfifo_load(rx_load),
      .rxfifo_empty(rx_empty), .rxfifo_rd(rd_b),
      .txfifo_load(tx_load), .txfifo_full(tx_full), .txfifo_wr(wr_b), .txfifo_data(txd_b),
      .phases(ph_b), .read_error(err_b), .commit(com_b)
   );

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One byte presented for exactly one rising edge; returns at the following falling edge.
   task automatic send(input logic [7:0] b);
      @(negedge clk);
      rx_data  = b;
      rx_valid = 1'b1;
      rx_empty = 1'b0;
      @(negedge clk);
      rx_valid = 1'b0;
      rx_empty = 1'b1;
   endtask

   task automatic collect(input bit use_b, input int cycles, output int cnt, output logic [15:0] dat);
      cnt = 0;
      dat = '0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk);
         if (!use_b && wr_a) begin cnt++; dat = {dat[7:0], txd_a}; end
         if (use_b && wr_b)  begin cnt++; dat = {dat[7:0], txd_b}; end
      end
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1;
      rx_data = '0; rx_valid = 1'b0; rx_empty = 1'b0; tx_full = 1'b0;
      rx_load = '0; tx_load = '0;
      repeat (3) @(negedge clk);
      chk("rst_phases", 128'(ph_a), 128'(0));
      chk("rst_rd", 128'(rd_a), 128'(0));
      chk("rst_err", 128'(err_a), 128'(0));
      chk("rst_commit", 128'(com_a), 128'(0));
      chk("rst_wr", 128'(wr_a), 128'(0));
      chk("rst_txdata", 128'(txd_a), 128'(0));
      rst_a = 1'b0; rst_b = 1'b0; rx_empty = 1'b1;
      @(negedge clk);
      chk("rd_empty", 128'(rd_a), 128'(0));
      rx_empty = 1'b0;
      #1 chk("rd_idle", 128'(rd_a), 128'(1));
      rx_empty = 1'b1;

      // SET then COMMIT
      send(8'h01); send(8'h03); send(8'h7F);
      chk("set_no_direct", 128'(ph_a), 128'(0));
      chk("set_no_err", 128'(err_a), 128'(0));
      send(8'h03);
      exp_a = '0; exp_a[3] = 8'h7F;
      chk("commit_pulse", 128'(com_a), 128'(1));
      chk("commit_phases", 128'(ph_a), 128'(exp_a));
      @(negedge clk);
      chk("commit_one_cycle", 128'(com_a), 128'(0));

      // BURST 00..09 then COMMIT
      send(8'h02);
      for (int i = 0; i < 10; i++) send(8'(i));
      chk("burst_no_direct", 128'(ph_a), 128'(exp_a));
      send(8'h03);
      for (int i = 0; i < 10; i++) exp_a[i] = 8'(i);
      chk("burst_phases", 128'(ph_a), 128'(exp_a));

      // Out-of-range SET and unknown opcode
      send(8'h01); send(8'h0C);
      chk("badaddr_early", 128'(err_a), 128'(0));
      send(8'h55);
      chk("badaddr_err", 128'(err_a), 128'(1));
      @(negedge clk);
      chk("badaddr_err_1cyc", 128'(err_a), 128'(0));
      send(8'h03);
      chk("badaddr_shadow", 128'(ph_a), 128'(exp_a));
      send(8'h77);
      chk("badop_err", 128'(err_a), 128'(1));
      @(negedge clk);
      chk("badop_err_1cyc", 128'(err_a), 128'(0));

      // READ phases[3] under TX backpressure
      send(8'h01); send(8'h03); send(8'h7F); send(8'h03);
      exp_a[3] = 8'h7F;
      chk("read_setup", 128'(ph_a), 128'(exp_a));
      tx_full = 1'b1;
      send(8'h04); send(8'h03);
      rx_empty = 1'b0;
      #1 chk("rd_in_tx", 128'(rd_a), 128'(0));
      rx_empty = 1'b1;
      collect(1'b0, 5, nwr, wdat);
      chk("read_held_full", 128'(nwr), 128'(0));
      tx_full = 1'b0;
      collect(1'b0, 6, nwr, wdat);
      chk("read_writes", 128'(nwr), 128'(1));
      chk("read_byte", 128'(wdat[7:0]), 128'(8'h7F));

      // READ of a nonexistent channel
      send(8'h04); send(8'h0C);
      chk("read_bad_err", 128'(err_a), 128'(1));
      collect(1'b0, 4, nwr, wdat);
      chk("read_bad_nowr", 128'(nwr), 128'(0));

      // Stall mid-SET until the watchdog fires
      send(8'h01); send(8'h05);
      n = 0;
      while (err_a !== 1'b1 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      chk("timeout_cycles", 128'(n), 128'(1024));
      @(negedge clk);
      chk("timeout_err_1cyc", 128'(err_a), 128'(0));
      send(8'h03);
      chk("timeout_commit", 128'(com_a), 128'(1));
      chk("timeout_phases", 128'(ph_a), 128'(exp_a));

      // Reset in the middle of a SET
      send(8'h01); send(8'h02);
      @(negedge clk); rst_a = 1'b1;
      @(negedge clk); rst_a = 1'b0;
      chk("midrst_phases", 128'(ph_a), 128'(0));
      send(8'h03);
      chk("midrst_opcode", 128'(com_a), 128'(1));
      chk("midrst_shadow", 128'(ph_a), 128'(0));

      // 12-bit phases: two-byte big-endian data
      @(negedge clk); rst_b = 1'b1;
      @(negedge clk); rst_b = 1'b0;
      chk("b_rst_phases", 128'(ph_b), 128'(0));
      send(8'h01); send(8'h02); send(8'h0A); send(8'hBC); send(8'h03);
      exp_b = '0; exp_b[2] = 12'hABC;
      chk("b_commit", 128'(com_b), 128'(1));
      chk("b_phases", 128'(ph_b), 128'(exp_b));
      send(8'h04); send(8'h02);
      collect(1'b1, 6, nwr, wdat);
      chk("b_read_writes", 128'(nwr), 128'(2));
      chk("b_read_bytes", 128'(wdat), 128'(16'h0ABC));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
